// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and shifts it out one bit per clock on sout/soutb, with gapless back-to-back words.
module piso_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             soutb,
    output logic             frame,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             r_sout;
    logic             w_sout_nxt;
    logic             r_soutb;
    logic             r_frame;
    logic             w_frame_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_last;
    logic             w_accept;

    assign w_last     = (r_state == S_SHIFT) && (r_cnt == '0);
    assign load_ready = ~res & ((r_state == S_IDLE) | w_last);
    assign w_accept   = load_valid & load_ready;

    // r_shift holds the bits not yet presented, aligned so the next one sits at the output end
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_sout_nxt  = r_sout;
        w_frame_nxt = r_frame;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_sout_nxt  = 1'b0;
                w_frame_nxt = 1'b0;
            end
            S_SHIFT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                    if (LSB_FIRST) begin
                        w_sout_nxt  = r_shift[0];
                        w_shift_nxt = r_shift >> 1;
                    end else begin
                        w_sout_nxt  = r_shift[WIDTH-1];
                        w_shift_nxt = r_shift << 1;
                    end
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_sout_nxt  = 1'b0;
                    w_frame_nxt = 1'b0;
                    w_shift_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // An accept overrides the shift/idle path; done from a finishing word is kept
        if (w_accept) begin
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = CW'(WIDTH - 1);
            w_frame_nxt = 1'b1;
            if (LSB_FIRST) begin
                w_sout_nxt  = din[0];
                w_shift_nxt = din >> 1;
            end else begin
                w_sout_nxt  = din[WIDTH-1];
                w_shift_nxt = din << 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_sout  <= 1'b0;
            r_soutb <= 1'b1;
            r_frame <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_sout  <= w_sout_nxt;
            r_soutb <= ~w_sout_nxt;
            r_frame <= w_frame_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign sout  = r_sout;
    assign soutb = r_soutb;
    assign frame = r_frame;
    assign done  = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: LSB-first and MSB-first instances share stimulus and are
// checked every cycle against a queue-of-pending-bits model.
module tb_piso_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] din = '0;

    logic rdy_a, sout_a, soutb_a, frame_a, done_a;
    logic rdy_b, sout_b, soutb_b, frame_b, done_b;

    int n_vec = 0;
    int n_err = 0;

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .res(res), .load_valid(load_valid), .load_ready(rdy_a), .din(din),
        .sout(sout_a), .soutb(soutb_a), .frame(frame_a), .done(done_a)
    );

    piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .res(res), .load_valid(load_valid), .load_ready(rdy_b), .din(din),
        .sout(sout_b), .soutb(soutb_b), .frame(frame_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Model: q[0] is the bit currently on the line; queue empty means idle
    bit qa[$];
    bit qb[$];
    bit exp_done = 1'b0;
    bit model_ok = 1'b0;

    always @(posedge clk) begin
        if (res) begin
            qa.delete();
            qb.delete();
            exp_done = 1'b0;
            model_ok = 1'b1;
        end else begin
            bit acc;
            acc      = load_valid && (qa.size() <= 1);
            exp_done = (qa.size() == 1);
            if (qa.size() > 0) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (acc) begin
                for (int k = 0; k < W; k++) begin
                    qa.push_back(din[k]);
                    qb.push_back(din[W-1-k]);
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            logic ea, eb, er, ef;
            ef = (qa.size() > 0);
            ea = ef ? qa[0] : 1'b0;
            eb = ef ? qb[0] : 1'b0;
            er = !res && (qa.size() <= 1);
            check("lsb.sout",  sout_a,  ea);
            check("lsb.soutb", soutb_a, ~ea);
            check("lsb.frame", frame_a, ef);
            check("lsb.done",  done_a,  exp_done);
            check("lsb.ready", rdy_a,   er);
            check("msb.sout",  sout_b,  eb);
            check("msb.soutb", soutb_b, ~eb);
            check("msb.frame", frame_b, ef);
            check("msb.done",  done_b,  exp_done);
            check("msb.ready", rdy_b,   er);
        end
    end

    // Present a word with load_valid high and return just after its accept edge
    task automatic send(input logic [W-1:0] w);
        int n;
        load_valid = 1'b1;
        din        = w;
        n          = 0;
        while (!rdy_a && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            n_err++;
            $display("FAIL send_timeout: ready stayed %b, required 1", rdy_a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic record(output logic [7:0] sa, output logic [7:0] sb);
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            sa[k] = sout_a;
            sb[k] = sout_b;
        end
    endtask

    initial begin
        logic [7:0] sa, sb;

        // Power-up reset
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
        @(negedge clk);
        check("rst.ready_after", rdy_a, 1'b1);
        check("rst.soutb_idle", soutb_a, 1'b1);
        #1;

        // LSB-first / MSB-first single word 8'hC1
        send(8'hC1);
        load_valid = 1'b0;
        record(sa, sb);
        check8("lsb.seq_C1", sa, 8'hC1);
        check8("msb.seq_C1", sb, 8'h83);
        @(negedge clk);
        check("done_after_C1", done_a, 1'b1);
        #1;

        // Back-to-back C1 then 5A with valid held
        send(8'hC1);
        send(8'h5A);
        load_valid = 1'b0;
        record(sa, sb);
        check8("lsb.seq_5A", sa, 8'h5A);
        check8("msb.seq_5A", sb, 8'h5A);
        repeat (3) @(posedge clk);
        #1;

        // Reset during bit 4 of 8'hFF aborts the word
        send(8'hFF);
        load_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        res = 1'b1;
        @(negedge clk);
        check("rst.ready_low", rdy_a, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort.sout", sout_a, 1'b0);
        check("abort.done", done_a, 1'b0);
        #1;
        res = 1'b0;
        send(8'h01);
        load_valid = 1'b0;
        record(sa, sb);
        check8("lsb.seq_01", sa, 8'h01);
        check8("msb.seq_01", sb, 8'h80);
        repeat (2) @(posedge clk);
        #1;

        // Mid-word load_valid pulse with 8'h00 must be ignored
        send(8'hA5);
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        load_valid = 1'b1;
        din        = 8'h00;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("no_extra_word", frame_a, 1'b0);

        // Random traffic with occasional resets
        repeat (600) begin
            @(negedge clk);
            #1;
            res        = ($urandom_range(0, 59) == 0);
            load_valid = ($urandom_range(0, 3) != 0);
            din        = W'($urandom);
        end
        res        = 1'b0;
        load_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
